// File: rtl/dewindow_pkg.sv
// dewindow_pkg: shared constants, state encoding and numerator-width helper for dewindow_stream.
// Contents: SIZE/W/SCALE defaults, NUM_W derived from them, IDX_W, MAX_OUT, state_t.
package dewindow_pkg;
    localparam int SIZE = 8;
    localparam int W = 7;
    localparam int SCALE = 100;

    // Smallest width whose range exceeds the largest rounded numerator.
    function automatic int num_w_calc(input int w, input int scale);
        int lim;
        int n;
        lim = ((1 << w) - 1) * scale + ((1 << w) - 1) / 2;
        n = 1;
        while ((1 << n) <= lim) n++;
        return n;
    endfunction

    localparam int NUM_W = num_w_calc(W, SCALE);
    localparam int IDX_W = $clog2(SIZE);
    localparam int MAX_OUT = (1 << W) - 1;

    typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;
endpackage

// File: rtl/dewindow_stream_seq_div_u.sv
// seq_div_u: unsigned restoring divider, one quotient bit per cycle, MSB first.
// Ports: clk, rst (sync, active-high); start loads num/den; busy while iterating;
//        done pulses one cycle with quo valid (held until next start).
// A zero divisor runs a single dummy step so the caller sees done one cycle later.
module seq_div_u
    import dewindow_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [W-1:0]     den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quo
);
    localparam int CW = $clog2(NUM_W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  d;
    logic [CW-1:0] cnt;
    logic [W:0]    trial;
    logic [W:0]    diff;
    logic          ge;

    assign trial = {rem, quo[NUM_W-1]};
    assign ge    = trial >= {1'b0, d};
    assign diff  = trial - {1'b0, d};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            d    <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem  <= '0;
                d    <= den;
                quo  <= num;
                cnt  <= (den == '0) ? CW'(1) : CW'(NUM_W);
                busy <= 1'b1;
            end else if (busy) begin
                rem <= ge ? diff[W-1:0] : trial[W-1:0];
                quo <= {quo[NUM_W-2:0], ge};
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/dewindow_stream.sv
// dewindow_stream: divides windowed samples by their per-index coefficient and streams the result.
// Ports: clk, rst (sync, active-high); coeff_i packed SIZE*W coefficients;
//        in_valid/in_ready/in_data input handshake; out_valid/out_ready output handshake;
//        out_data (saturated), out_index, out_sat, out_last.
// Build option: DEWINDOW_ROUND_EN adds den/2 to the numerator for round-to-nearest.
module dewindow_stream
    import dewindow_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE*W-1:0]   coeff_i,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic [IDX_W-1:0]    out_index,
    output logic                out_sat,
    output logic                out_last
);
    state_t           state;
    state_t           nxt;
    logic [IDX_W-1:0] index;
    logic             zero;
    logic             accept;
    logic             busy;
    logic             done;
    logic             sat;
    logic [W-1:0]     den_sel;
    logic [NUM_W:0]   num_full;
    logic [NUM_W-1:0] quo;

    assign den_sel = coeff_i[index*W +: W];
`ifdef DEWINDOW_ROUND_EN
    assign num_full = (NUM_W+1)'(in_data) * (NUM_W+1)'(SCALE) + (NUM_W+1)'(den_sel >> 1);
`else
    assign num_full = (NUM_W+1)'(in_data) * (NUM_W+1)'(SCALE);
`endif
    assign sat = zero || (quo > NUM_W'(MAX_OUT));

    seq_div_u u_div (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .num   (num_full[NUM_W-1:0]),
        .den   (den_sel),
        .busy  (busy),
        .done  (done),
        .quo   (quo)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = in_valid  ? DIV  : IDLE;
            DIV:     nxt = done      ? HOLD : DIV;
            HOLD:    nxt = out_ready ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == HOLD;
        accept    = in_ready && in_valid;
        out_index = index;
        out_last  = index == IDX_W'(SIZE - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index    <= '0;
            zero     <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            if (accept) zero <= den_sel == '0;
            if (state == DIV && done) begin
                out_data <= sat ? W'(MAX_OUT) : quo[W-1:0];
                out_sat  <= sat;
            end
            if (out_valid && out_ready) index <= out_last ? '0 : index + IDX_W'(1);
        end
    end
endmodule

// File: tb/tb_dewindow_stream.sv
// tb_dewindow_stream: directed and randomized checks of dewindow_stream against an arithmetic model.
module tb_dewindow_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [55:0] coeff_i;
    logic [6:0]  cf [8];
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  out_data;
    logic [2:0]  out_index;
    logic        out_sat;
    logic        out_last;
    int          checks = 0;
    int          errors = 0;
    int          idx = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_pack
        assign coeff_i[g*7 +: 7] = cf[g];
    end

    dewindow_stream dut (
        .clk       (clk),
        .rst       (rst),
        .coeff_i   (coeff_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_sat   (out_sat),
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int d, input int c, output int q, output int s);
        int n;
        if (c == 0) begin
            q = 127;
            s = 1;
            return;
        end
        n = d * 100;
`ifdef DEWINDOW_ROUND_EN
        n = n + c / 2;
`endif
        q = n / c;
        s = (q > 127) ? 1 : 0;
        if (s == 1) q = 127;
    endfunction

    task automatic xfer(input int d, input int hold);
        int c, eq, es, lat, t;
        logic [6:0] sd;
        logic       ss;
        c = int'(cf[idx]);
        model(d, c, eq, es);
        in_data  = 7'(d);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 7'($urandom);
        cf[idx]  = ~cf[idx];
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, (c == 0) ? 2 : 15);
        chk("out_data", out_data, eq);
        chk("out_sat", out_sat, es);
        chk("out_index", out_index, idx);
        chk("out_last", out_last, (idx == 7) ? 1 : 0);
        chk("busy_not_ready", in_ready, 0);
        sd = out_data;
        ss = out_sat;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, sd);
            chk("hold_sat", out_sat, ss);
            chk("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        cf[idx] = 7'(c);
        chk("drop_valid", out_valid, 0);
        chk("back_ready", in_ready, 1);
        idx = (idx + 1) % 8;
    endtask

    initial begin
        int seen;
        for (int k = 0; k < 8; k++) cf[k] = 7'($urandom_range(1, 127));
        cf[0] = 7'd100;
        cf[1] = 7'd54;
        cf[2] = 7'd8;
        cf[3] = 7'd8;
        cf[4] = 7'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ready", in_ready, 1);

        xfer(50, 0);
        xfer(27, 0);
        xfer(1, 0);
        xfer(127, 5);
        xfer(5, 1);
        for (int k = 0; k < 4; k++) xfer(int'($urandom_range(0, 127)), int'($urandom_range(0, 2)));
        chk("wrap_index", idx, 1);

        while (idx != 4) xfer(int'($urandom_range(0, 127)), 0);
        cf[4] = 7'd37;
        in_data  = 7'd90;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abandoned_no_valid", seen, 0);
        chk("abandoned_index", out_index, 0);
        idx = 0;
        xfer(int'($urandom_range(0, 127)), 0);

        for (int k = 0; k < 24; k++) begin
            cf[idx] = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            xfer(int'($urandom_range(0, 127)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
